flip_line: RTL and testbench

FLIP_LINE -- requirements
Module: flip_line

---
 rtl/reversi_pkg.sv | 35 +++
 rtl/dir_step.sv | 40 ++++
 rtl/flip_line.sv | 153 +++++++++++++++
 tb/tb_flip_line.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reversi_pkg.sv
// Shared Reversi definitions: cell codes, ray directions, the flip FSM state
// type and the packed board geometry.
package reversi_pkg;

    // 64 cells, 2 bits each.
    localparam int BOARD_W = 128;

    // Cell codes. Any code with bit 1 clear reads as empty.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] BLACK = 2'b11;
    localparam logic [1:0] WHITE = 2'b10;

    // Ray direction codes as (dx, dy) steps.
    localparam logic [2:0] DIR_UP    = 3'b000;  // ( 0,-1)
    localparam logic [2:0] DIR_DOWN  = 3'b001;  // ( 0,+1)
    localparam logic [2:0] DIR_LEFT  = 3'b010;  // (-1, 0)
    localparam logic [2:0] DIR_RIGHT = 3'b011;  // (+1, 0)
    localparam logic [2:0] DIR_UL    = 3'b100;  // (-1,-1)
    localparam logic [2:0] DIR_DL    = 3'b101;  // (-1,+1)
    localparam logic [2:0] DIR_UR    = 3'b110;  // (+1,-1)
    localparam logic [2:0] DIR_DR    = 3'b111;  // (+1,+1)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FLIP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit offset of cell (cx,cy) inside the packed board.
    function automatic logic [6:0] cell_base(input logic [2:0] cx, input logic [2:0] cy);
        return {cy, cx, 1'b0};
    endfunction

endpackage

// File: rtl/dir_step.sv
// One step along a Reversi ray: next coordinates plus an off-board flag.
// Coordinates are 4-bit signed so that a step past an edge shows up as -1 or 8
// instead of wrapping into the neighbouring row or column.
module dir_step
    import reversi_pkg::*;
(
    input  logic signed [3:0] cx,
    input  logic signed [3:0] cy,
    input  logic [2:0]        direction,
    output logic signed [3:0] nx,
    output logic signed [3:0] ny,
    output logic              offboard
);

    logic signed [3:0] dx;
    logic signed [3:0] dy;

    // Decode the direction into a unit step and apply it.
    always_comb begin
        dx = 4'sd0;
        dy = 4'sd0;
        case (direction)
            DIR_UP:    begin dx =  4'sd0; dy = -4'sd1; end
            DIR_DOWN:  begin dx =  4'sd0; dy =  4'sd1; end
            DIR_LEFT:  begin dx = -4'sd1; dy =  4'sd0; end
            DIR_RIGHT: begin dx =  4'sd1; dy =  4'sd0; end
            DIR_UL:    begin dx = -4'sd1; dy = -4'sd1; end
            DIR_DL:    begin dx = -4'sd1; dy =  4'sd1; end
            DIR_UR:    begin dx =  4'sd1; dy = -4'sd1; end
            DIR_DR:    begin dx =  4'sd1; dy =  4'sd1; end
            default:   begin dx =  4'sd0; dy =  4'sd0; end
        endcase
        nx = cx + dx;
        ny = cy + dy;
        // From an on-board cell a step lands in -1..8; both -1 (1111) and
        // 8 (1000) are exactly the results with bit 3 set.
        offboard = nx[3] | ny[3];
    end

endmodule

// File: rtl/flip_line.sv
// Reversi single-ray flipper. Given the origin of a just-placed disc and a ray
// direction, scans outward one cell per cycle counting opponent discs; if the
// run is closed by a mover disc, walks the ray again turning each counted disc
// to the mover colour. The origin cell itself is never written.
//
// Handshake: start is a one-cycle request honoured only while busy is low; the
// inputs x, y, direction, player_black and board_in are captured on that edge.
// busy stays high until the cycle in which done pulses for exactly one cycle;
// flipped, flip_count and board_out are final while done is high and hold
// until the next accepted start. Starts seen while busy are dropped.
module flip_line
    import reversi_pkg::*;
#(
    parameter int BOARD_W = reversi_pkg::BOARD_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [2:0]         x,
    input  logic [2:0]         y,
    input  logic [2:0]         direction,
    input  logic               player_black,
    input  logic [BOARD_W-1:0] board_in,
    output logic               busy,
    output logic               done,
    output logic               flipped,
    output logic [2:0]         flip_count,
    output logic [BOARD_W-1:0] board_out
);

    state_t            state;
    logic [2:0]        dir_r;
    logic              blk_r;
    logic signed [3:0] cur_x;
    logic signed [3:0] cur_y;
    logic signed [3:0] first_x;
    logic signed [3:0] first_y;
    logic              off;      // cursor has left the board
    logic [2:0]        cnt;      // opponent discs seen on the ray
    logic [2:0]        left;     // discs still to flip

    logic signed [3:0] step_cx;
    logic signed [3:0] step_cy;
    logic [2:0]        step_dir;
    logic signed [3:0] next_x;
    logic signed [3:0] next_y;
    logic              next_off;

    logic [1:0]        mover;
    logic [1:0]        opp;
    logic [1:0]        cur_cell;

    // In IDLE the stepper works from the incoming origin; otherwise from the cursor.
    assign step_cx  = (state == IDLE) ? {1'b0, x} : cur_x;
    assign step_cy  = (state == IDLE) ? {1'b0, y} : cur_y;
    assign step_dir = (state == IDLE) ? direction : dir_r;

    assign mover    = {1'b1, blk_r};
    assign opp      = {1'b1, ~blk_r};
    assign cur_cell = board_out[cell_base(cur_x[2:0], cur_y[2:0]) +: 2];

    dir_step u_step (
        .cx        (step_cx),
        .cy        (step_cy),
        .direction (step_dir),
        .nx        (next_x),
        .ny        (next_y),
        .offboard  (next_off)
    );

    // Control FSM with registered outputs and the working board.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            flipped    <= 1'b0;
            flip_count <= 3'd0;
            board_out  <= '0;
            dir_r      <= 3'd0;
            blk_r      <= 1'b0;
            cur_x      <= 4'sd0;
            cur_y      <= 4'sd0;
            first_x    <= 4'sd0;
            first_y    <= 4'sd0;
            off        <= 1'b0;
            cnt        <= 3'd0;
            left       <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dir_r      <= direction;
                        blk_r      <= player_black;
                        board_out  <= board_in;
                        cur_x      <= next_x;
                        cur_y      <= next_y;
                        first_x    <= next_x;
                        first_y    <= next_y;
                        // An off-board first step is resolved by SCAN on the
                        // next cycle, which is where that failure completes.
                        off        <= next_off;
                        cnt        <= 3'd0;
                        left       <= 3'd0;
                        flipped    <= 1'b0;
                        flip_count <= 3'd0;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (!off && cur_cell == opp) begin
                        cnt   <= cnt + 3'd1;
                        cur_x <= next_x;
                        cur_y <= next_y;
                        off   <= next_off;
                    end else if (!off && cur_cell == mover && cnt != 3'd0) begin
                        cur_x <= first_x;
                        cur_y <= first_y;
                        left  <= cnt;
                        state <= FLIP;
                    end else begin
                        // Off board, empty cell, or mover with nothing between.
                        done       <= 1'b1;
                        flipped    <= 1'b0;
                        flip_count <= 3'd0;
                        state      <= DONE;
                    end
                end
                FLIP: begin
                    board_out[cell_base(cur_x[2:0], cur_y[2:0]) +: 2] <= mover;
                    cur_x <= next_x;
                    cur_y <= next_y;
                    left  <= left - 3'd1;
                    if (left == 3'd1) begin
                        done       <= 1'b1;
                        flipped    <= 1'b1;
                        flip_count <= cnt;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flip_line.sv
// Bench for flip_line: directed board scenarios, reset handling, ignored
// starts while busy, and randomized rays against a reference model.
module tb_flip_line;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [2:0]   x;
    logic [2:0]   y;
    logic [2:0]   direction;
    logic         player_black;
    logic [127:0] board_in;
    logic         busy;
    logic         done;
    logic         flipped;
    logic [2:0]   flip_count;
    logic [127:0] board_out;

    int n_checks = 0;
    int n_fail   = 0;

    int dxs[8] = '{0, 0, -1, 1, -1, -1, 1, 1};
    int dys[8] = '{-1, 1, 0, 0, -1, 1, -1, 1};

    localparam logic [1:0] C_EMPTY = 2'b00;
    localparam logic [1:0] C_BLACK = 2'b11;
    localparam logic [1:0] C_WHITE = 2'b10;

    flip_line #(.BOARD_W(128)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .x            (x),
        .y            (y),
        .direction    (direction),
        .player_black (player_black),
        .board_in     (board_in),
        .busy         (busy),
        .done         (done),
        .flipped      (flipped),
        .flip_count   (flip_count),
        .board_out    (board_out)
    );

    // clock
    always #5 clk = ~clk;

    // global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] put(input logic [127:0] b, input int cx, input int cy,
                                         input logic [1:0] c);
        b[2*(8*cy+cx) +: 2] = c;
        return b;
    endfunction

    function automatic logic [1:0] get(input logic [127:0] b, input int cx, input int cy);
        return b[2*(8*cy+cx) +: 2];
    endfunction

    function automatic logic [127:0] rand_board();
        logic [127:0] b;
        int v;
        b = '0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom_range(0, 7);
            b[2*i +: 2] = (v == 0) ? 2'b00 : (v == 1) ? 2'b01 : (v <= 4) ? C_WHITE : C_BLACK;
        end
        return b;
    endfunction

    // Reference: walk the ray with plain integer coordinates.
    task automatic model(input logic [127:0] b, input int ox, input int oy, input int dir,
                         input bit blk, output logic [127:0] nb, output bit fl,
                         output int k, output int lat);
        logic [1:0] me;
        logic [1:0] them;
        int cx;
        int cy;
        int j;
        bit fin;
        me   = {1'b1, blk};
        them = {1'b1, ~blk};
        nb   = b;
        fl   = 1'b0;
        k    = 0;
        lat  = 0;
        j    = 0;
        fin  = 1'b0;
        cx   = ox + dxs[dir];
        cy   = oy + dys[dir];
        while (!fin) begin
            if (cx < 0 || cx > 7 || cy < 0 || cy > 7) begin
                lat = j + 1;
                fin = 1'b1;
            end else if (get(b, cx, cy) == them) begin
                j  = j + 1;
                cx = cx + dxs[dir];
                cy = cy + dys[dir];
            end else if (get(b, cx, cy) == me && j > 0) begin
                fl  = 1'b1;
                k   = j;
                lat = 2 * j + 1;
                for (int i = 1; i <= j; i++) nb = put(nb, ox + i * dxs[dir], oy + i * dys[dir], me);
                fin = 1'b1;
            end else begin
                lat = j + 1;
                fin = 1'b1;
            end
        end
    endtask

    // Driver: issue one start and measure edges until done.
    task automatic do_move(input int ox, input int oy, input int dir, input bit blk,
                           input logic [127:0] b, output int edges, output logic [127:0] ob,
                           output bit ofl, output int ocnt, output bit done_after,
                           output bit busy_after);
        @(negedge clk);
        x            = 3'(ox);
        y            = 3'(oy);
        direction    = 3'(dir);
        player_black = blk;
        board_in     = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        board_in = ~b;
        edges    = 0;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        ob   = board_out;
        ofl  = flipped;
        ocnt = int'(flip_count);
        @(posedge clk);
        #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        resetn    = 1'b1;
        start     = 1'b0;
        x         = 3'd2;
        y         = 3'd3;
        direction = 3'd3;
        player_black = 1'b1;
        board_in  = '1;
        repeat (2) @(posedge clk);
        // start together with reset must be lost
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        start  = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (flipped !== 1'b0) begin n_fail++; $display("FAIL reset_flipped: got %b expected 0", flipped); end
        n_checks++;
        if (flip_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", flip_count); end
        n_checks++;
        if (board_out !== 128'd0) begin n_fail++; $display("FAIL reset_board: got %h expected 0", board_out); end
    endtask

    task automatic test_directed();
        logic [127:0] b;
        logic [127:0] exp_b;
        logic [127:0] ob;
        int edges;
        int cnt;
        bit fl;
        bit da;
        bit ba;

        // horizontal single flip
        b     = put(put('0, 3, 3, C_WHITE), 4, 3, C_BLACK);
        exp_b = put(b, 3, 3, C_BLACK);
        do_move(2, 3, 3, 1'b1, b, edges, ob, fl, cnt, da, ba);
        n_checks++;
        if (edges !== 3) begin n_fail++; $display("FAIL single_latency: got %0d expected 3", edges); end
        n_checks++;
        if (fl !== 1'b1 || cnt !== 1) begin n_fail++; $display("FAIL single_result: got fl=%b cnt=%0d expected fl=1 cnt=1", fl, cnt); end
        n_checks++;
        if (ob !== exp_b) begin n_fail++; $display("FAIL single_board: got %h expected %h", ob, exp_b); end
        n_checks++;
        if (da !== 1'b0 || ba !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got done=%b busy=%b expected 0 0", da, ba); end
        // board holds in IDLE while board_in changes
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (board_out !== exp_b) begin n_fail++; $display("FAIL idle_hold: got %h expected %h", board_out, exp_b); end

        // full diagonal
        b = put('0, 7, 7, C_BLACK);
        for (int i = 1; i <= 6; i++) b = put(b, i, i, C_WHITE);
        exp_b = b;
        for (int i = 1; i <= 6; i++) exp_b = put(exp_b, i, i, C_BLACK);
        do_move(0, 0, 7, 1'b1, b, edges, ob, fl, cnt, da, ba);
        n_checks++;
        if (edges !== 13) begin n_fail++; $display("FAIL diag_latency: got %0d expected 13", edges); end
        n_checks++;
        if (fl !== 1'b1 || cnt !== 6) begin n_fail++; $display("FAIL diag_result: got fl=%b cnt=%0d expected fl=1 cnt=6", fl, cnt); end
        n_checks++;
        if (ob !== exp_b) begin n_fail++; $display("FAIL diag_board: got %h expected %h", ob, exp_b); end

        // run into the edge
        b = put(put('0, 6, 3, C_WHITE), 7, 3, C_WHITE);
        do_move(5, 3, 3, 1'b1, b, edges, ob, fl, cnt, da, ba);
        n_checks++;
        if (edges !== 3) begin n_fail++; $display("FAIL edge_latency: got %0d expected 3", edges); end
        n_checks++;
        if (fl !== 1'b0 || cnt !== 0) begin n_fail++; $display("FAIL edge_result: got fl=%b cnt=%0d expected fl=0 cnt=0", fl, cnt); end
        n_checks++;
        if (ob !== b) begin n_fail++; $display("FAIL edge_board: got %h expected %h", ob, b); end

        // first step off board
        b = rand_board();
        do_move(3, 0, 0, 1'b0, b, edges, ob, fl, cnt, da, ba);
        n_checks++;
        if (edges !== 1) begin n_fail++; $display("FAIL offfirst_latency: got %0d expected 1", edges); end
        n_checks++;
        if (fl !== 1'b0 || cnt !== 0 || ob !== b) begin n_fail++; $display("FAIL offfirst_result: got fl=%b cnt=%0d board=%h expected fl=0 cnt=0 board=%h", fl, cnt, ob, b); end

        // first step empty
        b = put(rand_board(), 3, 1, C_EMPTY);
        do_move(3, 0, 1, 1'b0, b, edges, ob, fl, cnt, da, ba);
        n_checks++;
        if (edges !== 1) begin n_fail++; $display("FAIL empty_latency: got %0d expected 1", edges); end
        n_checks++;
        if (fl !== 1'b0 || cnt !== 0 || ob !== b) begin n_fail++; $display("FAIL empty_result: got fl=%b cnt=%0d board=%h expected fl=0 cnt=0 board=%h", fl, cnt, ob, b); end
    endtask

    task automatic test_random();
        logic [127:0] b;
        logic [127:0] exp_b;
        logic [127:0] ob;
        int ox, oy, dir, k, cx, cy, edges, cnt, exp_k, exp_lat;
        bit blk, fl, exp_fl, da, ba;
        for (int it = 0; it < 60; it++) begin
            b   = rand_board();
            ox  = $urandom_range(0, 7);
            oy  = $urandom_range(0, 7);
            dir = $urandom_range(0, 7);
            blk = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                // lay a bracketed run along the ray where it fits
                k  = $urandom_range(1, 6);
                cx = ox;
                cy = oy;
                for (int i = 1; i <= k + 1; i++) begin
                    cx = cx + dxs[dir];
                    cy = cy + dys[dir];
                    if (cx >= 0 && cx <= 7 && cy >= 0 && cy <= 7)
                        b = put(b, cx, cy, (i <= k) ? {1'b1, ~blk} : {1'b1, blk});
                end
            end
            model(b, ox, oy, dir, blk, exp_b, exp_fl, exp_k, exp_lat);
            do_move(ox, oy, dir, blk, b, edges, ob, fl, cnt, da, ba);
            n_checks++;
            if (edges !== exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, edges, exp_lat); end
            n_checks++;
            if (fl !== exp_fl || cnt !== exp_k) begin n_fail++; $display("FAIL rand_result[%0d]: got fl=%b cnt=%0d expected fl=%b cnt=%0d", it, fl, cnt, exp_fl, exp_k); end
            n_checks++;
            if (ob !== exp_b) begin n_fail++; $display("FAIL rand_board[%0d]: got %h expected %h", it, ob, exp_b); end
            n_checks++;
            if (da !== 1'b0) begin n_fail++; $display("FAIL rand_pulse[%0d]: done still %b one cycle later, expected 0", it, da); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] b;
        logic [127:0] exp_b;
        logic [127:0] ob;
        int ndone;
        int lat;
        b = put('0, 7, 7, C_BLACK);
        for (int i = 1; i <= 6; i++) b = put(b, i, i, C_WHITE);
        exp_b = b;
        for (int i = 1; i <= 6; i++) exp_b = put(exp_b, i, i, C_BLACK);
        ndone = 0;
        lat   = 0;
        ob    = '0;
        @(negedge clk);
        x = 3'd0; y = 3'd0; direction = 3'd7; player_black = 1'b1; board_in = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 3) begin
                x = 3'd7; y = 3'd7; direction = 3'd4; player_black = 1'b0;
                board_in = '1; start = 1'b1;
            end
            if (cyc == 4) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin lat = cyc; ob = board_out; end
            end
        end
        n_checks++;
        if (ndone !== 1) begin n_fail++; $display("FAIL busy_ignore_pulses: got %0d done pulses expected 1", ndone); end
        n_checks++;
        if (lat !== 13) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d expected 13", lat); end
        n_checks++;
        if (ob !== exp_b) begin n_fail++; $display("FAIL busy_ignore_board: got %h expected %h", ob, exp_b); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid_flip();
        logic [127:0] b;
        logic [127:0] partial;
        int ndone;
        b = put('0, 7, 7, C_BLACK);
        for (int i = 1; i <= 6; i++) b = put(b, i, i, C_WHITE);
        partial = put(put(b, 1, 1, C_BLACK), 2, 2, C_BLACK);
        @(negedge clk);
        x = 3'd0; y = 3'd0; direction = 3'd7; player_black = 1'b1; board_in = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // six opponents, the closing disc, then two flips
        repeat (9) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || board_out !== partial) begin n_fail++; $display("FAIL midflip_state: got busy=%b board=%h expected busy=1 board=%h", busy, board_out, partial); end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || flipped !== 1'b0 || flip_count !== 3'd0) begin
            n_fail++;
            $display("FAIL midflip_reset_ctrl: got busy=%b done=%b flipped=%b count=%0d expected all 0", busy, done, flipped, flip_count);
        end
        n_checks++;
        if (board_out !== 128'd0) begin n_fail++; $display("FAIL midflip_reset_board: got %h expected 0", board_out); end
        ndone = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin n_fail++; $display("FAIL midflip_no_done: got %0d done pulses expected 0", ndone); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_flip();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
